clk_div_ctrl: RTL

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_pkg.sv | 12 +
 rtl/clk_div_cnt.sv | 35 +++
 rtl/clk_div_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam int MIN_RATIO = 2;

endpackage

// File: rtl/clk_div_cnt.sv
// Period counter for the clock divider: counts 0..ratio-1 and derives tick and the base output.
module clk_div_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run,
    input  logic             hold,
    input  logic [WIDTH-1:0] ratio,
    output logic             tick,
    output logic             p
);

    logic [WIDTH-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == (ratio - WIDTH'(1)));

    // Cleared while stopped and on the stop cycle itself, so the first running cycle sees 0.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!run || hold) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign tick = run & w_last;
    assign p    = run & (r_cnt < (ratio >> 1));

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock divider controller: FSM, ratio handshake and output shaping.
// Optional feature: define CLK_DIV_ODD_DUTY_EN for exact 50% duty on odd ratios.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int RESET_RATIO = 28
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_ratio,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] ratio_cur,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam logic [WIDTH-1:0] RESET_R = WIDTH'(RESET_RATIO);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_ratio;
    logic [WIDTH-1:0] r_pend;
    logic [WIDTH-1:0] w_ratio_nxt;
    logic [WIDTH-1:0] w_pend_nxt;
    logic             r_err;
    logic             w_accept;
    logic             w_bad;
    logic             w_take;
    logic             w_run;
    logic             w_tick;
    logic             w_p;

    // Handshake: a request transfers on a rising edge where cfg_valid and cfg_ready are both high.
    assign w_accept = cfg_valid & cfg_ready;
    assign w_bad    = cfg_ratio < WIDTH'(MIN_RATIO);
    assign w_take   = w_accept & ~w_bad;
    assign w_run    = (r_state != IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_ratio_nxt = r_ratio;
        w_pend_nxt  = r_pend;
        case (r_state)
            IDLE: begin
                if (w_take) w_ratio_nxt = cfg_ratio;
                if (en)     w_state_nxt = RUN;
            end
            RUN: begin
                if (!en) begin
                    w_state_nxt = IDLE;
                    if (w_take) w_ratio_nxt = cfg_ratio;
                end else if (w_take) begin
                    w_pend_nxt  = cfg_ratio;
                    w_state_nxt = PEND;
                end
            end
            PEND: begin
                // Stopping applies the waiting ratio so it is not lost.
                if (!en) begin
                    w_state_nxt = IDLE;
                    w_ratio_nxt = r_pend;
                end else if (w_tick) begin
                    w_ratio_nxt = r_pend;
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ratio <= RESET_R;
            r_pend  <= RESET_R;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ratio <= w_ratio_nxt;
            r_pend  <= w_pend_nxt;
            r_err   <= w_accept & w_bad;
        end
    end

    clk_div_cnt #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk_in (clk_in),
        .rst    (rst),
        .run    (w_run),
        .hold   (~en),
        .ratio  (r_ratio),
        .tick   (w_tick),
        .p      (w_p)
    );

`ifdef CLK_DIV_ODD_DUTY_EN
    logic r_n;

    // Half-cycle delayed copy of p stretches odd-ratio high time by half an input period.
    always_ff @(negedge clk_in or negedge rst) begin
        if (!rst) begin
            r_n <= 1'b0;
        end else begin
            r_n <= w_p;
        end
    end

    assign clk_out = r_ratio[0] ? (w_p | (r_n & w_run)) : w_p;
`else
    assign clk_out = w_p;
`endif

    assign tick      = w_tick;
    assign cfg_ready = (r_state != PEND);
    assign cfg_err   = r_err;
    assign busy      = (r_state == PEND);
    assign ratio_cur = r_ratio;
    assign state_dbg = r_state;

endmodule
